// File: rtl/spi_shift_module_if.sv
// spi_shift_module_if: controller-side handshake of the SPI shift engine
// (request/baud enable in, busy/received word/done back to the controller).
interface spi_shift_module_if #(parameter int DW = 8);
    logic          EnTx_Sig;
    logic          EnBuadcnt;
    logic [DW-1:0] Tx_Data;
    logic          Tx_Busy_Sig;
    logic [DW-1:0] Rx_Data;
    logic          Rx_Done_Sig;

    modport master (
        output EnTx_Sig, EnBuadcnt, Tx_Data,
        input  Tx_Busy_Sig, Rx_Data, Rx_Done_Sig
    );

    modport slave (
        input  EnTx_Sig, EnBuadcnt, Tx_Data,
        output Tx_Busy_Sig, Rx_Data, Rx_Done_Sig
    );
endinterface

// File: rtl/spi_shift_module.sv
// spi_shift_module: SPI mode-0 master shift engine, MSB first; SCLK derived
// from an internal half-period counter, MISO captured on SCLK rising edges.
module spi_shift_module #(
    parameter int DW       = 8,
    parameter int DIV_HALF = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    spi_shift_module_if.slave ctl,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI
);
    typedef enum logic [1:0] {IDLE, SHIFT, RELEASE} state_t;

    localparam int              BW      = $clog2(DW);
    localparam logic [7:0]      CNT_TOP = 8'(DIV_HALF - 1);
    localparam logic [BW-1:0]   BIT_TOP = BW'(DW - 1);

    state_t        state, state_n;
    logic [7:0]    cnt, cnt_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic [DW-1:0] tx_sr, tx_sr_n;
    logic [DW-1:0] rx_sr, rx_sr_n;
    logic [DW-1:0] rx_data, rx_data_n;
    logic          busy, busy_n;
    logic          sclk, sclk_n;
    logic          done, done_n;
    logic          start, tick;

    assign start = ctl.EnTx_Sig && ctl.EnBuadcnt;
    assign tick  = cnt == CNT_TOP;

    // MOSI is the MSB of the transmit register, so it only moves on loads,
    // falling toggles and aborts.
    assign MOSI            = tx_sr[DW-1];
    assign SCLK            = sclk;
    assign ctl.Tx_Busy_Sig = busy;
    assign ctl.Rx_Data     = rx_data;
    assign ctl.Rx_Done_Sig = done;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        tx_sr_n   = tx_sr;
        rx_sr_n   = rx_sr;
        rx_data_n = rx_data;
        busy_n    = busy;
        sclk_n    = sclk;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    tx_sr_n   = ctl.Tx_Data;
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    busy_n    = 1'b1;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (!ctl.EnBuadcnt) begin
                    sclk_n  = 1'b0;
                    busy_n  = 1'b0;
                    tx_sr_n = '0;
                    state_n = IDLE;
                end else if (!tick) begin
                    cnt_n = cnt + 8'd1;
                end else begin
                    cnt_n  = '0;
                    sclk_n = !sclk;
                    if (!sclk) begin
                        rx_sr_n = {rx_sr[DW-2:0], MISO};
                    end else if (bit_cnt != BIT_TOP) begin
                        tx_sr_n   = tx_sr << 1;
                        bit_cnt_n = bit_cnt + BW'(1);
                    end else begin
                        rx_data_n = rx_sr;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        state_n   = RELEASE;
                    end
                end
            end
            // Wait for the controller to drop the baud enable so a held
            // request cannot immediately retrigger.
            RELEASE: state_n = ctl.EnBuadcnt ? RELEASE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            sclk    <= 1'b0;
            done    <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            tx_sr   <= tx_sr_n;
            rx_sr   <= rx_sr_n;
            rx_data <= rx_data_n;
            busy    <= busy_n;
            sclk    <= sclk_n;
            done    <= done_n;
        end
    end
endmodule

// File: tb/tb_spi_shift_module.sv
// tb_spi_shift_module: bench for the SPI shift engine; dut0 uses default
// timing with a slave model, dut1 runs DIV_HALF=1 with MISO looped to MOSI.
module tb_spi_shift_module;
    localparam int DW = 8;

    logic CLK  = 1'b0;
    logic RSTn = 1'b1;
    always #5 CLK = ~CLK;

    spi_shift_module_if #(.DW(DW)) if0 ();
    spi_shift_module_if #(.DW(DW)) if1 ();

    logic       sclk0, sclk1, mosi0, mosi1, miso0;
    logic       en_tx[2];
    logic       en_b[2];
    logic [7:0] txd[2];

    assign if0.EnTx_Sig  = en_tx[0];
    assign if0.EnBuadcnt = en_b[0];
    assign if0.Tx_Data   = txd[0];
    assign if1.EnTx_Sig  = en_tx[1];
    assign if1.EnBuadcnt = en_b[1];
    assign if1.Tx_Data   = txd[1];

    spi_shift_module #(.DW(DW), .DIV_HALF(4)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .ctl(if0.slave),
        .MISO(miso0), .SCLK(sclk0), .MOSI(mosi0)
    );

    spi_shift_module #(.DW(DW), .DIV_HALF(1)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .ctl(if1.slave),
        .MISO(mosi1), .SCLK(sclk1), .MOSI(mosi1)
    );

    typedef struct { int g; logic [7:0] rx; logic [7:0] mosi; int busy; int rise; } obs_t;
    typedef struct { int g; logic [7:0] tx; logic [7:0] rx; int busy; } exp_t;
    typedef struct { int g; logic [7:0] tx; logic [7:0] sw; logic [7:0] rx; } vec_t;

    obs_t       obs_q[$];
    exp_t       sb[$];
    logic       sclk_q[2] = '{1'b0, 1'b0};
    logic       busy_q[2] = '{1'b0, 1'b0};
    int         busy_n[2] = '{0, 0};
    int         rise_n[2] = '{0, 0};
    int         done_tot[2] = '{0, 0};
    int         idle_edges = 0;
    logic [7:0] mosi_cap[2] = '{8'h00, 8'h00};
    logic [7:0] s_sr = 8'h00;
    logic [7:0] s_word = 8'h00;
    logic       csn = 1'b1;
    logic       ms, mb, mm, md;
    logic [7:0] mr;
    int         tests = 0;
    int         fails = 0;

    assign miso0 = s_sr[7];

    function automatic logic [11:0] outs(int g);
        return g ? {if1.Tx_Busy_Sig, sclk1, mosi1, if1.Rx_Done_Sig, if1.Rx_Data}
                 : {if0.Tx_Busy_Sig, sclk0, mosi0, if0.Rx_Done_Sig, if0.Rx_Data};
    endfunction

    // Monitor + slave model: one process observes both DUTs on the falling
    // CLK edge; the slave presents its MSB when busy rises and shifts on
    // every SCLK falling edge.
    always @(negedge CLK) begin
        for (int g = 0; g < 2; g++) begin
            {mb, ms, mm, md, mr} = outs(g);
            if (mb && !busy_q[g]) begin
                busy_n[g] = 0;
                rise_n[g] = 0;
                if (g == 0) s_sr = s_word;
            end
            if (mb) busy_n[g]++;
            if (ms && !sclk_q[g]) begin
                rise_n[g]++;
                mosi_cap[g] = {mosi_cap[g][6:0], mm};
            end
            if (g == 0 && !ms && sclk_q[g]) s_sr = s_sr << 1;
            if (g == 0 && csn && ms != sclk_q[g]) idle_edges++;
            if (md) begin
                done_tot[g]++;
                obs_q.push_back('{g, mr, mosi_cap[g], busy_n[g], rise_n[g]});
            end
            sclk_q[g] = ms;
            busy_q[g] = mb;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic run_frame(int g, logic [7:0] tx, logic [7:0] sw, logic [7:0] rx, int hold, bit keep);
        int   d0, n, ie;
        exp_t e;
        obs_t o;
        step();
        d0     = done_tot[g];
        s_word = sw;
        txd[g] = tx;
        en_tx[g] = 1'b1;
        en_b[g]  = 1'b1;
        csn    = 1'b0;
        sb.push_back('{g, tx, rx, 2 * DW * (g ? 1 : 4)});
        step();
        step();
        check("busy_at_check", outs(g)[11], 1'b1);
        txd[g] = ~tx;
        n = 0;
        while (obs_q.size() == 0 && n < 200) begin
            step();
            n++;
        end
        e = sb.pop_front();
        check("done_seen", obs_q.size(), 1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            check("dut_idx", o.g, e.g);
            check("rx_data", o.rx, e.rx);
            check("mosi_bits", o.mosi, e.tx);
            check("busy_cycles", o.busy, e.busy);
            check("sclk_rises", o.rise, DW);
        end
        step();
        check("done_width", done_tot[g] - d0, 1);
        check("done_low", outs(g)[8], 1'b0);
        repeat (hold) begin
            step();
            check("release_idle", outs(g)[11:10], 2'b00);
        end
        en_b[g] = 1'b0;
        csn     = 1'b1;
        if (!keep) en_tx[g] = 1'b0;
        ie = idle_edges;
        repeat (3) step();
        check("csn_high_quiet", idle_edges - ie, 0);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{0, 8'hA5, 8'h3C, 8'h3C};
        vecs[1] = '{0, 8'h5A, 8'hC3, 8'hC3};
        vecs[2] = '{0, 8'h00, 8'hFF, 8'hFF};
        vecs[3] = '{1, 8'hFF, 8'h00, 8'hFF};
        vecs[4] = '{1, 8'h00, 8'hFF, 8'h00};
        for (int g = 0; g < 2; g++) begin
            en_tx[g] = 1'b0;
            en_b[g]  = 1'b0;
            txd[g]   = 8'h00;
        end

        // Reset with random controller inputs, then release with baud disabled.
        #2 RSTn = 1'b0;
        repeat (3) begin
            for (int g = 0; g < 2; g++) begin
                en_tx[g] = 1'($urandom);
                en_b[g]  = 1'($urandom);
                txd[g]   = 8'($urandom);
            end
            step();
            check("reset_outs0", outs(0), 12'h000);
            check("reset_outs1", outs(1), 12'h000);
        end
        for (int g = 0; g < 2; g++) begin
            en_tx[g] = 1'b1;
            en_b[g]  = 1'b0;
        end
        RSTn = 1'b1;
        repeat (6) begin
            step();
            check("no_baud_idle", {outs(0)[11:10], outs(1)[11:10]}, 4'h0);
        end
        en_tx[0] = 1'b0;
        en_tx[1] = 1'b0;

        foreach (vecs[i]) run_frame(vecs[i].g, vecs[i].tx, vecs[i].sw, vecs[i].rx, 0, 1'b0);

        // Controller loop: request held high, baud re-armed after each frame.
        for (int i = 0; i < 3; i++) run_frame(0, 8'h81, 8'h3C, 8'h3C, 3, 1'b1);
        en_tx[0] = 1'b0;
        step();

        // Abort 21 cycles into SHIFT, while SCLK is high and MOSI is bit 5 of 0xF0.
        txd[0] = 8'hF0;
        en_tx[0] = 1'b1;
        en_b[0]  = 1'b1;
        csn = 1'b0;
        repeat (21) step();
        check("pre_abort_sclk_mosi", outs(0)[11:9], 3'b111);
        en_b[0] = 1'b0;
        step();
        check("abort_outs", outs(0)[11:9], 3'b000);
        en_tx[0] = 1'b0;
        repeat (5) step();
        check("abort_no_done", obs_q.size(), 0);
        check("abort_rx_kept", outs(0)[7:0], 8'h3C);
        csn = 1'b1;

        // Reset mid-frame, then a clean frame.
        step();
        txd[0] = 8'h5A;
        en_tx[0] = 1'b1;
        en_b[0]  = 1'b1;
        csn = 1'b0;
        repeat (30) step();
        RSTn = 1'b0;
        #1;
        check("midframe_reset", outs(0), 12'h000);
        en_tx[0] = 1'b0;
        en_b[0]  = 1'b0;
        csn = 1'b1;
        step();
        RSTn = 1'b1;
        run_frame(0, 8'h55, 8'hC6, 8'hC6, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_shift_module.md
Name: spi_shift_module

Overview:
- SPI master shift engine (mode 0: CPOL=0, CPHA=0, MSB first), directly downstream of the SPI transaction controller.
- The controller drives CSN, EnTx_Sig and EnBuadcnt. This block generates SCLK from its internal baud counter, shifts Tx_Data out on MOSI and captures MISO into Rx_Data.
- Tx_Busy_Sig returns to the controller so it can release CSN when the frame ends.

Parameters:
- DW, 8, frame width in bits; legal 2..16.
- DIV_HALF, 4, CLK cycles per SCLK half-period; legal 1..255; internal counter is 8 bits.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- EnTx_Sig  in  1  transfer request level from controller.
- EnBuadcnt  in  1  baud enable from controller; high for the whole frame.
- Tx_Data  in  DW  word to transmit; sampled only at start.
- MISO  in  1  serial data from slave.
- Tx_Busy_Sig  out  1  high while a frame is shifting.
- SCLK  out  1  SPI clock, idle low.
- MOSI  out  1  serial data to slave.
- Rx_Data  out  DW  last completed received word.
- Rx_Done_Sig  out  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (async, RSTn=0): Tx_Busy_Sig=0, SCLK=0, MOSI=0, Rx_Data=0, Rx_Done_Sig=0, state=IDLE, baud counter=0, bit counter=0, tx/rx shift registers=0.
- All outputs are registered.
- States: IDLE, SHIFT, RELEASE.
- IDLE:
  - Start condition is EnTx_Sig=1 AND EnBuadcnt=1.
  - On start: tx_sr<=Tx_Data; MOSI<=Tx_Data[DW-1]; baud cnt<=0; bit cnt<=0; Tx_Busy_Sig<=1; go SHIFT.
  - Tx_Busy_Sig is therefore high from the cycle after start is sampled. The controller samples it 2 cycles after its own En, so it must see it high.
- SHIFT:
  - Baud cnt increments every cycle.
  - When cnt==DIV_HALF-1: cnt<=0 and SCLK toggles.
  - Rising toggle (SCLK 0->1): rx_sr<={rx_sr[DW-2:0],MISO}.
  - Falling toggle (SCLK 1->0), bit cnt != DW-1: tx_sr shifts left; MOSI<=next bit; bit cnt++.
  - Falling toggle, bit cnt == DW-1: Rx_Data<=rx_sr; Rx_Done_Sig<=1; Tx_Busy_Sig<=0; go RELEASE.
  - MOSI changes only on falling toggles, so it is stable DIV_HALF cycles before every rising edge.
- Timing:
  - Tx_Busy_Sig is high exactly 2*DW*DIV_HALF cycles (64 at defaults).
  - SCLK sees exactly DW rising edges per frame.
  - The first rising edge occurs DIV_HALF cycles after the first SHIFT cycle.
- RELEASE:
  - Rx_Done_Sig<=0 (pulse width exactly 1).
  - Remain here until EnBuadcnt=0, then go IDLE.
  - This prevents a spurious restart while the controller is still deasserting. A held-high EnTx_Sig produces the next frame only after the controller re-arms EnBuadcnt.
- Abort:
  - If EnBuadcnt=0 in any SHIFT cycle: SCLK<=0, Tx_Busy_Sig<=0, MOSI<=0, go IDLE.
  - On abort, no Rx_Done_Sig pulse and Rx_Data is unchanged.
- EnTx_Sig dropping mid-frame is ignored; only EnBuadcnt aborts.
- Tx_Data changes during SHIFT do not affect the frame in flight.
- Rx_Data holds its value until the next completed frame.
- Reset mid-frame: immediate return to reset values; SCLK low with no glitch pulse beyond the async clear.

Test Plan:
1. Assert RSTn=0 for 3 cycles with random inputs -> all outputs 0, SCLK 0; no activity on release with EnBuadcnt=0.
2. Defaults, Tx_Data=0xA5, slave model returns 0x3C MSB-first changing on SCLK falling edges -> MOSI at the 8 rising edges = 1,0,1,0,0,1,0,1; Tx_Busy_Sig high 64 cycles; Rx_Done_Sig single pulse; Rx_Data=0x3C.
3. Connected to the controller, En held high for 200 cycles with Tx_Data=0x81 -> back-to-back frames, each bracketed by CSN low. Tx_Busy_Sig is high on the controller's check cycle. RELEASE is left only after EnBuadcnt falls, with no extra SCLK edges while CSN=1.
4. Abort: drop EnBuadcnt 20 cycles into SHIFT -> next cycle SCLK=0, Tx_Busy_Sig=0; no Rx_Done_Sig; Rx_Data keeps its previous value 0x3C.
5. RSTn pulsed low at cycle 30 of a frame -> outputs reset immediately. A new frame 0x55 then completes normally, with Rx_Data matching the slave model's word.
6. DIV_HALF=1, DW=8, MISO tied to MOSI, Tx_Data=0xFF then 0x00 -> SCLK=CLK/2, Tx_Busy_Sig high 16 cycles per frame, Rx_Data=0xFF then 0x00.
